// File: rtl/driver_word_serializer.sv
// Serializes FIFO words over LANES serial lines with shift clock and latch.
// Define SERIALIZER_LSB_FIRST_EN to shift each lane LSB first.
module driver_word_serializer #(
   parameter int DATA_WIDTH    = 192,
   parameter int LANES         = 16,
   parameter int BITS_PER_LANE = 12,
   parameter int SCLK_HALF     = 1,
   parameter int LATCH_CYCLES  = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   output logic                  rd,
   input  logic                  rd_strobe,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  sclk,
   output logic [LANES-1:0]      sdata,
   output logic                  latch,
   output logic                  busy,
   output logic                  underrun,
   output logic                  overrun,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   localparam int BW = (BITS_PER_LANE > 1) ? $clog2(BITS_PER_LANE) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_LANE - 1);
   localparam logic [4:0]    PH_RISE  = 5'(SCLK_HALF - 1);
   localparam logic [4:0]    PH_LAST  = 5'(2 * SCLK_HALF - 1);
   localparam logic [3:0]    LAT_LAST = 4'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  hold_valid;
   logic                  cap_pend;
   logic                  started;
   logic [BW-1:0]         bit_cnt;
   logic [4:0]            phase_cnt;
   logic [3:0]            lat_cnt;

   assign rd = ~hold_valid & ~cap_pend;

   function automatic logic [LANES-1:0] lane_bits(
      input logic [DATA_WIDTH-1:0] w,
      input logic [BW-1:0]         b
   );
      logic [LANES-1:0] r;
      logic [IW-1:0]    idx;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
         idx = IW'(k * BITS_PER_LANE + int'(b));
`else
         idx = IW'(k * BITS_PER_LANE + BITS_PER_LANE - 1 - int'(b));
`endif
         r[k] = w[idx];
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         hold        <= '0;
         shreg       <= '0;
         hold_valid  <= 1'b0;
         cap_pend    <= 1'b0;
         started     <= 1'b0;
         bit_cnt     <= '0;
         phase_cnt   <= '0;
         lat_cnt     <= '0;
         sclk        <= 1'b0;
         sdata       <= '0;
         latch       <= 1'b0;
         busy        <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
         frame_count <= '0;
      end else begin
         underrun <= 1'b0;
         // A strobe while the buffer is occupied drops the word.
         if (rd_strobe) begin
            if (hold_valid | cap_pend) overrun  <= 1'b1;
            else                       cap_pend <= 1'b1;
         end
         if (cap_pend) begin
            hold       <= data_in;
            hold_valid <= 1'b1;
            cap_pend   <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (hold_valid) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               shreg      <= hold;
               hold_valid <= 1'b0;
               bit_cnt    <= '0;
               phase_cnt  <= '0;
               started    <= 1'b1;
               sclk       <= 1'b0;
               sdata      <= lane_bits(hold, '0);
               state      <= SHIFT;
            end
            SHIFT: begin
               if (phase_cnt == PH_RISE) sclk <= 1'b1;
               if (phase_cnt == PH_LAST) begin
                  sclk      <= 1'b0;
                  phase_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     sdata       <= '0;
                     latch       <= 1'b1;
                     lat_cnt     <= '0;
                     frame_count <= frame_count + CNT_WIDTH'(1);
                     state       <= LATCH;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     sdata   <= lane_bits(shreg, bit_cnt + BW'(1));
                  end
               end else begin
                  phase_cnt <= phase_cnt + 5'd1;
               end
            end
            LATCH: begin
               if (lat_cnt == LAT_LAST) begin
                  latch <= 1'b0;
                  if (hold_valid) begin
                     state <= LOAD;
                  end else begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     underrun <= started;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
